data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Two-port byte-serial data memory controller, big-endian, round-robin grant.
// Define DMEM_CTRL_FIXED_PRIO_EN for fixed priority (port 0 wins every tie).
module data_mem_ctrl #(
  parameter int MEM_BYTES = 2000,
  parameter int ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic [31:0]       p0_rdata,
  output logic              p0_done,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic [31:0]       p1_rdata,
  output logic              p1_done,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic              mem_re
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_DONE
  } state_t;

  localparam logic [31:0] LP_MEM = 32'(MEM_BYTES);

  state_t            r_state;
  state_t            w_next;
  logic              r_port;
  logic              r_we;
  logic              r_err;
  logic [1:0]        r_size;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_shift;
  logic [31:0]       r_p0_rdata;
  logic [31:0]       r_p1_rdata;

  logic              w_any;
  logic              w_gnt1;
  logic              w_we;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic [31:0]       w_wd_al;
  logic [2:0]        w_nb;
  logic [31:0]       w_end;
  logic              w_bad;
  logic [1:0]        w_cnt_last;
  logic              w_last;
  logic              w_xfer;
  logic [31:0]       w_ld_val;

  assign w_any = p0_req | p1_req;

`ifdef DMEM_CTRL_FIXED_PRIO_EN
  assign w_gnt1 = p1_req & ~p0_req;
`else
  // r_last is the port granted most recently; the other one wins a tie
  logic r_last;
  assign w_gnt1 = p1_req & (~p0_req | ~r_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (r_state == S_IDLE && w_any) begin
      r_last <= w_gnt1;
    end
  end
`endif

  assign w_we    = w_gnt1 ? p1_we    : p0_we;
  assign w_size  = w_gnt1 ? p1_size  : p0_size;
  assign w_addr  = w_gnt1 ? p1_addr  : p0_addr;
  assign w_wdata = w_gnt1 ? p1_wdata : p0_wdata;

  always_comb begin
    w_nb    = 3'd4;
    w_wd_al = w_wdata;
    unique case (w_size)
      2'b00: begin
        w_nb    = 3'd1;
        w_wd_al = {w_wdata[7:0], 24'b0};
      end
      2'b01: begin
        w_nb    = 3'd2;
        w_wd_al = {w_wdata[15:0], 16'b0};
      end
      default: ;
    endcase
  end

  assign w_end = 32'(w_addr) + 32'(w_nb);
  assign w_bad = (w_size == 2'b11)
               | (w_size == 2'b01 & w_addr[0])
               | (w_size == 2'b10 & |w_addr[1:0])
               | (w_end > LP_MEM);

  assign w_cnt_last = (r_size == 2'b00) ? 2'd0 :
                      (r_size == 2'b01) ? 2'd1 : 2'd3;
  assign w_last     = (r_cnt == w_cnt_last);
  assign w_ld_val   = {r_shift[23:0], mem_rdata};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_any) w_next = w_bad ? S_DONE : S_XFER;
      S_XFER: if (w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // One shift register serves both directions: stores shift the
  // left-aligned operand out of the top, loads shift bytes in at the bottom.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_port     <= 1'b0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= 2'b00;
      r_cnt      <= 2'd0;
      r_addr     <= '0;
      r_shift    <= 32'd0;
      r_p0_rdata <= 32'd0;
      r_p1_rdata <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_port  <= w_gnt1;
            r_we    <= w_we;
            r_size  <= w_size;
            r_addr  <= w_addr;
            r_err   <= w_bad;
            r_cnt   <= 2'd0;
            r_shift <= w_we ? w_wd_al : 32'd0;
          end
        end
        S_XFER: begin
          r_cnt   <= w_last ? 2'd0 : r_cnt + 2'd1;
          r_shift <= w_ld_val;
          if (w_last && !r_we) begin
            if (r_port) r_p1_rdata <= w_ld_val;
            else        r_p0_rdata <= w_ld_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_xfer    = (r_state == S_XFER);
  assign mem_we    = w_xfer & r_we;
  assign mem_re    = w_xfer & ~r_we;
  assign mem_addr  = w_xfer ? r_addr + ADDR_W'(r_cnt) : '0;
  assign mem_wdata = mem_we ? r_shift[31:24] : 8'd0;

  assign p0_done  = (r_state == S_DONE) & ~r_port;
  assign p1_done  = (r_state == S_DONE) & r_port;
  assign p0_err   = p0_done & r_err;
  assign p1_err   = p1_done & r_err;
  assign p0_rdata = r_p0_rdata;
  assign p1_rdata = r_p1_rdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed and random accesses
// against a byte-array reference model of the attached memory.
module tb_data_mem_ctrl;

  localparam int MB = 2000;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          p0_req = 0, p0_we = 0;
  logic [1:0]    p0_size = 0;
  logic [AW-1:0] p0_addr = 0;
  logic [31:0]   p0_wdata = 0;
  logic [31:0]   p0_rdata;
  logic          p0_done, p0_err;
  logic          p1_req = 0, p1_we = 0;
  logic [1:0]    p1_size = 0;
  logic [AW-1:0] p1_addr = 0;
  logic [31:0]   p1_wdata = 0;
  logic [31:0]   p1_rdata;
  logic          p1_done, p1_err;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic          mem_we, mem_re;

  logic [7:0] tb_mem  [0:4095];
  logic [7:0] ref_mem [0:4095];

  int checks = 0;
  int failures = 0;
  int model_last = 1;
  logic [31:0] hold [2];
  logic        hold_ok [2];

  data_mem_ctrl #(.MEM_BYTES(MB), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rdata(p0_rdata),
    .p0_done(p0_done), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rdata(p1_rdata),
    .p1_done(p1_done), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_re(mem_re)
  );

  always #5 clk = ~clk;

  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

  // Reference: legality rules and big-endian byte placement.
  function automatic void model(input logic we, input logic [1:0] size,
                                input logic [11:0] addr, input logic [31:0] wd,
                                output logic err, output logic [31:0] rd,
                                output int nb);
    int a;
    a  = int'(addr);
    nb = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    err = (size == 3) || (a % nb != 0) || (a + nb > MB);
    rd = 0;
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        if (we) ref_mem[a+i] = 8'(wd >> (8 * (nb - 1 - i)));
        else    rd = (rd << 8) | 32'(ref_mem[a+i]);
      end
    end else begin
      nb = 0;
    end
  endfunction

  task automatic do_access(input int port, input logic we,
                           input logic [1:0] size, input logic [11:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic er, output int lat,
                           output logic st, output logic xl);
    logic dn;
    @(negedge clk);
    if (port == 0) begin
      p0_we = we; p0_size = size; p0_addr = addr; p0_wdata = wd; p0_req = 1;
    end else begin
      p1_we = we; p1_size = size; p1_addr = addr; p1_wdata = wd; p1_req = 1;
    end
    lat = 0; st = 0; xl = 0; dn = 0;
    while (!dn && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_we || mem_re) st = 1;
      if (port == 0 && (p1_done || p1_err)) xl = 1;
      if (port == 1 && (p0_done || p0_err)) xl = 1;
      if ((port == 0) ? p0_done : p1_done) dn = 1;
      else lat++;
    end
    if (!dn) lat = 99;
    rd = (port == 0) ? p0_rdata : p1_rdata;
    er = (port == 0) ? p0_err : p1_err;
    p0_req = 0;
    p1_req = 0;
    model_last = port;
    @(posedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (p0_done !== 0 || p1_done !== 0 || p0_err !== 0 || p1_err !== 0) begin
      failures++;
      $display("FAIL reset_done got=%b%b%b%b exp=0000", p0_done, p1_done, p0_err, p1_err);
    end
    checks++;
    if (p0_rdata !== 0 || p1_rdata !== 0) begin
      failures++;
      $display("FAIL reset_rdata got=%h/%h exp=0", p0_rdata, p1_rdata);
    end
    checks++;
    if (mem_we !== 0 || mem_re !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
      failures++;
      $display("FAIL reset_mem got we=%b re=%b a=%h d=%h exp=0", mem_we, mem_re, mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset = 0;
    model_last = 1;
    hold[0] = 0; hold[1] = 0;
    hold_ok[0] = 1; hold_ok[1] = 1;
  endtask

  task automatic test_directed();
    logic [31:0] rd, mr;
    logic er, st, xl, me;
    int lat, nb;
    model(1, 2, 12'h010, 32'hDEADBEEF, me, mr, nb);
    do_access(0, 1, 2, 12'h010, 32'hDEADBEEF, rd, er, lat, st, xl);
    checks++;
    if (er !== 0 || lat != 4) begin
      failures++;
      $display("FAIL st_word got err=%b lat=%0d exp err=0 lat=4", er, lat);
    end
    checks++;
    if ({tb_mem[16], tb_mem[17], tb_mem[18], tb_mem[19]} !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL st_bytes got=%h%h%h%h exp=deadbeef", tb_mem[16], tb_mem[17], tb_mem[18], tb_mem[19]);
    end
    model(0, 2, 12'h010, 0, me, mr, nb);
    do_access(0, 0, 2, 12'h010, 0, rd, er, lat, st, xl);
    checks++;
    if (rd !== 32'hDEADBEEF || lat != 4 || xl) begin
      failures++;
      $display("FAIL ld_word got=%h lat=%0d xl=%b exp=deadbeef lat=4", rd, lat, xl);
    end
    model(0, 1, 12'h012, 0, me, mr, nb);
    do_access(0, 0, 1, 12'h012, 0, rd, er, lat, st, xl);
    checks++;
    if (rd !== 32'h0000BEEF || lat != 2) begin
      failures++;
      $display("FAIL ld_half got=%h lat=%0d exp=0000beef lat=2", rd, lat);
    end
    model(0, 0, 12'h013, 0, me, mr, nb);
    do_access(0, 0, 0, 12'h013, 0, rd, er, lat, st, xl);
    checks++;
    if (rd !== 32'h000000EF || lat != 1) begin
      failures++;
      $display("FAIL ld_byte got=%h lat=%0d exp=000000ef lat=1", rd, lat);
    end
    do_access(0, 0, 2, 12'h011, 0, rd, er, lat, st, xl);
    checks++;
    if (er !== 1 || lat != 0 || st !== 0) begin
      failures++;
      $display("FAIL misalign got err=%b lat=%0d strobe=%b exp 1 0 0", er, lat, st);
    end
    do_access(0, 0, 2, 12'd1998, 0, rd, er, lat, st, xl);
    checks++;
    if (er !== 1 || lat != 0) begin
      failures++;
      $display("FAIL word_1998 got err=%b lat=%0d exp err=1 lat=0", er, lat);
    end
    do_access(0, 1, 2, 12'd2000, 32'h1, rd, er, lat, st, xl);
    checks++;
    if (er !== 1 || st !== 0) begin
      failures++;
      $display("FAIL word_2000 got err=%b strobe=%b exp err=1 strobe=0", er, st);
    end
    model(1, 0, 12'd1999, 32'h5A, me, mr, nb);
    do_access(0, 1, 0, 12'd1999, 32'h5A, rd, er, lat, st, xl);
    do_access(0, 0, 0, 12'd1999, 0, rd, er, lat, st, xl);
    checks++;
    if (er !== 0 || rd !== 32'h5A || lat != 1) begin
      failures++;
      $display("FAIL byte_1999 got err=%b rd=%h lat=%0d exp 0 5a 1", er, rd, lat);
    end
    do_access(0, 0, 3, 12'h000, 0, rd, er, lat, st, xl);
    checks++;
    if (er !== 1 || lat != 0 || st !== 0) begin
      failures++;
      $display("FAIL size3 got err=%b lat=%0d strobe=%b exp 1 0 0", er, lat, st);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, mr, wd;
    logic er, st, xl, me, we;
    logic [1:0] sz;
    logic [11:0] a;
    int lat, nb, port, r, o;
    hold_ok[0] = 0;
    for (int k = 0; k < 40; k++) begin
      port = $urandom_range(0, 1);
      we   = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 9);
      sz   = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      wd   = $urandom;
      if ($urandom_range(0, 3) == 0) a = 12'($urandom_range(1990, 2047));
      else                           a = 12'($urandom_range(0, 1999));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 1) a[0] = 0;
        if (sz == 2) a[1:0] = 0;
      end
      model(we, sz, a, wd, me, mr, nb);
      do_access(port, we, sz, a, wd, rd, er, lat, st, xl);
      checks++;
      if (er !== me || lat != nb) begin
        failures++;
        $display("FAIL rnd_err_lat k=%0d got err=%b lat=%0d exp err=%b lat=%0d", k, er, lat, me, nb);
      end
      checks++;
      if (st !== !me || xl !== 0) begin
        failures++;
        $display("FAIL rnd_strobe k=%0d got strobe=%b xleak=%b exp %b 0", k, st, xl, !me);
      end
      if (!me && !we) begin
        checks++;
        if (rd !== mr) begin
          failures++;
          $display("FAIL rnd_rdata k=%0d a=%h sz=%0d got=%h exp=%h", k, a, sz, rd, mr);
        end
      end
      o = 1 - port;
      if (hold_ok[o]) begin
        checks++;
        if (((o == 0) ? p0_rdata : p1_rdata) !== hold[o]) begin
          failures++;
          $display("FAIL rnd_hold k=%0d port=%0d got=%h exp=%h", k, o, (o == 0) ? p0_rdata : p1_rdata, hold[o]);
        end
      end
      hold[port]    = mr;
      hold_ok[port] = !me && !we;
    end
  endtask

  task automatic test_round_robin();
    int exp_first, first, n;
    for (int rep = 0; rep < 2; rep++) begin
`ifdef DMEM_CTRL_FIXED_PRIO_EN
      exp_first = 0;
`else
      exp_first = (model_last == 1) ? 0 : 1;
`endif
      @(negedge clk);
      p0_we = 0; p0_size = 2; p0_addr = 12'h010; p0_req = 1;
      p1_we = 0; p1_size = 2; p1_addr = 12'h020; p1_req = 1;
      n = 0;
      while (!(p0_done || p1_done) && n < 20) begin
        @(posedge clk); @(negedge clk); n++;
      end
      first = p1_done ? 1 : 0;
      checks++;
      if (n >= 20 || first != exp_first || (p0_done && p1_done)) begin
        failures++;
        $display("FAIL rr_first rep=%0d got=%0d exp=%0d n=%0d", rep, first, exp_first, n);
      end
      if (first == 0) p0_req = 0; else p1_req = 0;
      n = 0;
      while (!((first == 0) ? p1_done : p0_done) && n < 20) begin
        @(posedge clk); @(negedge clk); n++;
      end
      checks++;
      if (n >= 20) begin
        failures++;
        $display("FAIL rr_second rep=%0d got=timeout exp=done", rep);
      end
      p0_req = 0; p1_req = 0;
      model_last = 1 - first;
      @(posedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] old2, old3;
    logic seen;
    int n;
    old2 = ref_mem[12'h102];
    old3 = ref_mem[12'h103];
    @(negedge clk);
    p0_we = 1; p0_size = 2; p0_addr = 12'h100; p0_wdata = 32'h11223344; p0_req = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_we !== 1 || mem_addr !== 12'h102) begin
      failures++;
      $display("FAIL mid_xfer got we=%b a=%h exp we=1 a=102", mem_we, mem_addr);
    end
    reset = 1;
    #1;
    checks++;
    if (mem_we !== 0 || mem_re !== 0 || mem_addr !== 0 || p0_done !== 0 || p0_rdata !== 0 || p1_rdata !== 0) begin
      failures++;
      $display("FAIL mid_reset_out got we=%b a=%h done=%b rd=%h exp 0", mem_we, mem_addr, p0_done, p0_rdata);
    end
    p0_req = 0;
    @(negedge clk);
    reset = 0;
    model_last = 1;
    ref_mem[12'h100] = 8'h11;
    ref_mem[12'h101] = 8'h22;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (p0_done || p1_done) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL mid_nodone got done=1 exp done=0");
    end
    checks++;
    if ({tb_mem[12'h100], tb_mem[12'h101], tb_mem[12'h102], tb_mem[12'h103]} !== {8'h11, 8'h22, old2, old3}) begin
      failures++;
      $display("FAIL mid_bytes got=%h%h%h%h exp=1122%h%h", tb_mem[12'h100], tb_mem[12'h101], tb_mem[12'h102], tb_mem[12'h103], old2, old3);
    end
    p0_we = 0; p0_size = 0; p0_addr = 12'h100; p0_req = 1;
    p1_we = 0; p1_size = 0; p1_addr = 12'h101; p1_req = 1;
    n = 0;
    while (!(p0_done || p1_done) && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    checks++;
    if (n >= 20 || p0_done !== 1 || p0_rdata !== 32'h11) begin
      failures++;
      $display("FAIL mid_tie got p0_done=%b rd=%h exp 1 00000011", p0_done, p0_rdata);
    end
    p0_req = 0;
    n = 0;
    while (!p1_done && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    p1_req = 0;
    checks++;
    if (n >= 20 || p1_rdata !== 32'h22) begin
      failures++;
      $display("FAIL mid_p1 got rd=%h n=%0d exp 00000022", p1_rdata, n);
    end
    @(posedge clk);
  endtask

  task automatic test_mem_image();
    int bad;
    bad = 0;
    for (int i = 0; i < MB; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mem_image got=%0d differing bytes exp=0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tb_mem[i]  = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    test_reset();
    test_directed();
    test_random();
    test_round_robin();
    test_reset_mid();
    test_mem_image();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
